// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider that produces one quotient bit per clock.
// Handshakes: valid/ready on the operand side and on the result side.
// A zero divisor is detected at accept and bypasses the iteration.
// Optional build macro SEQ_DIVIDER_SIGNED_EN adds the signed_op port and
// two's-complement operation. Without it the block is unsigned only.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // The extra cycle with cnt == WIDTH is the one that loads the result registers.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] cnt;

    // Partial remainder is kept at WIDTH bits. After a restore it is always
    // below the divisor, so only the shifted value needs the extra bit.
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   p_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] ds_mag;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && (state == IDLE);
    assign last_iter = (cnt == CNT_LAST);

    // One restoring step: shift {P,Q} left and try to subtract the divisor.
    // diff is taken modulo 2^WIDTH; it is only used when ge holds, so the
    // true difference is below the divisor and fits.
    assign p_sh = {p, q[WIDTH-1]};
    assign ge   = (p_sh >= {1'b0, dvsr});
    assign diff = p_sh[WIDTH-1:0] - dvsr;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic signed [WIDTH-1:0] dd_s;
    logic signed [WIDTH-1:0] ds_s;
    logic                    dd_neg;
    logic                    ds_neg;
    logic                    neg_q;
    logic                    neg_r;

    // Negate when neg is set. The most negative value maps onto itself,
    // and read as unsigned it is the correct magnitude.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    assign dd_s   = dividend;
    assign ds_s   = divisor;
    assign dd_neg = signed_op && (dd_s < 0);
    assign ds_neg = signed_op && (ds_s < 0);
    assign dd_mag = apply_sign(dividend, dd_neg);
    assign ds_mag = apply_sign(divisor, ds_neg);

    // The quotient truncates toward zero. The remainder follows the dividend's sign.
    assign res_q  = apply_sign(q, neg_q);
    assign res_r  = apply_sign(p, neg_r);

    // Operand signs are captured at accept and applied when the result is loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_q <= dd_neg ^ ds_neg;
            neg_r <= dd_neg;
        end
    end
`else
    assign dd_mag = dividend;
    assign ds_mag = divisor;
    assign res_q  = q;
    assign res_r  = p;
`endif

    // Datapath: load operand magnitudes on accept, then run one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            p    <= '0;
            q    <= dd_mag;
            dvsr <= ds_mag;
        end else if ((state == CALC) && !last_iter) begin
            p <= ge ? diff : p_sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ge};
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (last_iter) begin
                        quotient  <= res_q;
                        remainder <= res_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8). It uses directed cases and
// random back-to-back traffic, and checks against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic         signed_op;
`endif
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Present operands and let them be taken on the next edge.
    // Returns at 1ns after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Count edges after the accept edge until out_valid is seen. A count of
    // n means out_valid first became visible after edge accept+n.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got=%0h want=0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got=%0h want=0", remainder); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        send(8'd100, 8'd7, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept in_ready never high"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_valid(cyc);
        // Result is visible after edge k+W+1, which is first sampled at edge k+W+2.
        checks++; if (cyc != W + 1) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", cyc, W + 1); end
        checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_quotient got=%0d want=14", quotient); end
        checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL basic_remainder got=%0d want=2", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b want=0", div_by_zero); end
        take();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_after_take out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_div_zero();
        bit ok;
        int cyc;
        send(8'd5, 8'd0, ok);
        wait_valid(cyc);
        checks++; if (cyc != 0) begin errors++; $display("FAIL dbz_latency got=%0d want=0", cyc); end
        checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dbz_quotient got=%0h want=ff", quotient); end
        checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dbz_remainder got=%0d want=5", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b want=1", div_by_zero); end
        take();
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got=%b want=0", div_by_zero); end
    endtask

    task automatic test_hold();
        bit ok;
        int cyc;
        int bad;
        logic [W-1:0] a_tab [2] = '{8'd255, 8'd3};
        logic [W-1:0] b_tab [2] = '{8'd1, 8'd200};
        logic [W-1:0] q_tab [2] = '{8'd255, 8'd0};
        logic [W-1:0] r_tab [2] = '{8'd0, 8'd3};
        for (int i = 0; i < 2; i++) begin
            send(a_tab[i], b_tab[i], ok);
            wait_valid(cyc);
            checks++; if (quotient !== q_tab[i] || remainder !== r_tab[i]) begin
                errors++; $display("FAIL hold_result%0d got=(%0d,%0d) want=(%0d,%0d)", i, quotient, remainder, q_tab[i], r_tab[i]);
            end
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                in_valid = c[0];
                dividend = W'($urandom);
                divisor  = W'($urandom);
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q_tab[i] || remainder !== r_tab[i]) bad++;
            end
            in_valid = 1'b0;
            checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable%0d got=%0d unstable cycles want=0", i, bad); end
            take();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release%0d out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        int cyc;
        send(8'd200, 8'd3, ok);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
        end
        checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL abort_data q=%0h r=%0h dbz=%b want 0/0/0", quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%b want=0", out_valid); end
        send(8'd50, 8'd5, ok);
        wait_valid(cyc);
        checks++; if (quotient !== 8'd10 || remainder !== 8'd0 || cyc != W + 1) begin
            errors++; $display("FAIL abort_after got=(%0d,%0d) lat=%0d want=(10,0) lat=%0d", quotient, remainder, cyc, W + 1);
        end
        take();
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        bit ok;
        int cyc;
        int sa;
        int sb;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        signed_op = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin a = 8'hF9; b = 8'd2; end
            else if (i == 1) begin a = 8'h80; b = 8'hFF; end
            else if (i == 2) begin a = 8'hF9; b = 8'd0; end
            else begin a = W'($urandom); b = W'($urandom); end
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sb == 0) begin eq = '1; er = a; end
            else begin eq = W'(sa / sb); er = W'(sa % sb); end
            send(a, b, ok);
            wait_valid(cyc);
            checks++; if (quotient !== eq || remainder !== er || div_by_zero !== (sb == 0)) begin
                errors++; $display("FAIL signed%0d %0d/%0d got=(%0h,%0h,%b) want=(%0h,%0h,%b)", i, sa, sb, quotient, remainder, div_by_zero, eq, er, sb == 0);
            end
            take();
        end
        signed_op = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int stall;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int got;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            send(a, b, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept%0d in_ready never high", i); end
            wait_valid(cyc);
            checks++; if (cyc != ((b == 0) ? 0 : W + 1)) begin errors++; $display("FAIL b2b_latency%0d got=%0d want=%0d", i, cyc, (b == 0) ? 0 : W + 1); end
            stall = $urandom_range(0, 4);
            repeat (stall) begin @(posedge clk); #1; end
            if (b == 0) begin
                checks++; if (quotient !== '1 || remainder !== a || div_by_zero !== 1'b1) begin
                    errors++; $display("FAIL b2b_dbz%0d got=(%0h,%0h,%b) want=(ff,%0h,1)", i, quotient, remainder, div_by_zero, a);
                end
            end else begin
                checks++; if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
                    errors++; $display("FAIL b2b_invariant%0d %0d/%0d got=(%0d,%0d)", i, a, b, quotient, remainder);
                end
                checks++; if (quotient !== W'(a / b) || remainder !== W'(a % b) || div_by_zero !== 1'b0) begin
                    errors++; $display("FAIL b2b_result%0d %0d/%0d got=(%0d,%0d) want=(%0d,%0d)", i, a, b, quotient, remainder, a / b, a % b);
                end
            end
            if (out_valid === 1'b1) got++;
            // Hold out_ready for a few cycles: exactly one result may transfer.
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_take%0d out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup%0d out_valid=%b want=0", i, out_valid); end
            end
            out_ready = 1'b0;
        end
        checks++; if (got != 40) begin errors++; $display("FAIL b2b_count got=%0d want=40", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_hold();
        test_reset_mid_calc();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
